// File: rtl/sweeper_pkg.sv
// Shared state encoding and table-indexing helpers for the truth-table sweeper.
package sweeper_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_DRIVE  = 2'd1;
  localparam logic [STATE_W-1:0] S_FINISH = 2'd2;

  // Number of input combinations for an n_in-input circuit.
  function automatic int unsigned vec_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Low bit of the table slice belonging to vector idx.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned n_out);
    return idx * n_out;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times how long each vector is held.
module hold_timer #(
  parameter int unsigned HOLD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int unsigned   CW     = $clog2(HOLD) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  // Count down while enabled; zero is registered alongside the count so it lines up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt  <= RELOAD;
      zero <= (RELOAD == '0);
    end else if (en && !zero) begin
      cnt  <= cnt - CW'(1);
      zero <= (cnt == CW'(1));
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input combination into a circuit under test, captures its truth table
// and scores it against an expected table.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned HOLD  = 10
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic [N_IN-1:0]                     vec,
  input  logic [N_OUT-1:0]                    resp,
  input  logic [vec_count(N_IN)*N_OUT-1:0]    exp_tbl,
  output logic [vec_count(N_IN)*N_OUT-1:0]    cap_tbl,
  output logic                                busy,
  output logic                                done,
  output logic [N_IN:0]                       mismatch_cnt,
  output logic                                pass
);

  localparam int unsigned     CNT_W    = N_IN + 1;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               accept;
  logic               sample;
  logic               last;
  logic               zero;
  logic               timer_load;
  logic               timer_en;
  logic [N_OUT-1:0]   exp_slice;
  logic               miss;
  logic [CNT_W-1:0]   cnt_nxt;

  // Expected response for the current vector and the scoring it implies.
  always_comb begin
    exp_slice = exp_tbl[slice_lo(32'(vec), N_OUT) +: N_OUT];
    miss      = (resp != exp_slice);
    cnt_nxt   = mismatch_cnt + CNT_W'(miss);
    last      = (vec == VEC_LAST);
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (zero) begin
          sample = 1'b1;
          if (last) state_nxt = S_FINISH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Reload on start and after every sample except the final one.
  always_comb begin
    timer_load = accept | (sample & ~last);
    timer_en   = (state == S_DRIVE);
  end

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .en    (timer_en),
    .zero  (zero)
  );

  // Vector register, capture table, mismatch counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec          <= '0;
      cap_tbl      <= '0;
      mismatch_cnt <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        vec          <= '0;
        cap_tbl      <= '0;
        mismatch_cnt <= '0;
        pass         <= 1'b0;
        busy         <= 1'b1;
      end else if (sample) begin
        cap_tbl[slice_lo(32'(vec), N_OUT) +: N_OUT] <= resp;
        mismatch_cnt <= cnt_nxt;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (cnt_nxt == '0);
        end else begin
          vec <= vec + N_IN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one instance with HOLD=10, one with HOLD=1.
module tb_truth_table_sweeper;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned N_OUT = 2;
  localparam int unsigned VN    = 8;
  localparam int unsigned TW    = VN * N_OUT;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic [TW-1:0] exp_tbl = '0;
  logic [TW-1:0] circ_tbl = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic [N_IN-1:0]  vec_a, vec_b;
  logic [N_OUT-1:0] resp_a, resp_b;
  logic [TW-1:0]    cap_a, cap_b;
  logic             busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [N_IN:0]    cnt_a, cnt_b;
  logic             start_a, start_b;

  // Circuit under test: a lookup of the current vector in circ_tbl.
  always_comb begin
    resp_a  = circ_tbl[int'(vec_a)*N_OUT +: N_OUT];
    resp_b  = circ_tbl[int'(vec_b)*N_OUT +: N_OUT];
    start_a = start & ~sel;
    start_b = start & sel;
  end

  wire [N_IN-1:0] vec_m  = sel ? vec_b  : vec_a;
  wire [TW-1:0]   cap_m  = sel ? cap_b  : cap_a;
  wire            busy_m = sel ? busy_b : busy_a;
  wire            done_m = sel ? done_b : done_a;
  wire            pass_m = sel ? pass_b : pass_a;
  wire [N_IN:0]   cnt_m  = sel ? cnt_b  : cnt_a;

  truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a), .resp(resp_a),
    .exp_tbl(exp_tbl), .cap_tbl(cap_a), .busy(busy_a), .done(done_a),
    .mismatch_cnt(cnt_a), .pass(pass_a)
  );

  truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(1)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b), .resp(resp_b),
    .exp_tbl(exp_tbl), .cap_tbl(cap_b), .busy(busy_b), .done(done_b),
    .mismatch_cnt(cnt_b), .pass(pass_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: number of vectors whose observed response differs from expectation.
  function automatic int ref_mismatch(input logic [TW-1:0] c, input logic [TW-1:0] e);
    int n = 0;
    for (int v = 0; v < int'(VN); v++)
      if (c[v*N_OUT +: N_OUT] != e[v*N_OUT +: N_OUT]) n++;
    return n;
  endfunction

  // D = A & B, E = ~C with vec = {A,B,C} and resp = {D,E}.
  function automatic logic [TW-1:0] and_not_tbl();
    logic [TW-1:0] t = '0;
    logic [2:0] b;
    for (int v = 0; v < int'(VN); v++) begin
      b = 3'(v);
      t[v*N_OUT +: N_OUT] = {b[2] & b[1], ~b[0]};
    end
    return t;
  endfunction

  // One sweep on the selected instance, checking the vector walk cycle by cycle.
  task automatic do_sweep(input bit d, input bit pulse_mid, input bit keep_start);
    int hold;
    int ecnt;
    bit got_done;
    hold = d ? 1 : 10;
    ecnt = ref_mismatch(circ_tbl, exp_tbl);
    sel  = d;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!keep_start) start = 1'b0;
    for (int k = 1; k <= int'(VN) * hold; k++) begin
      check_eq("walk", {vec_m, busy_m, done_m}, {3'((k - 1) / hold), 1'b1, 1'b0});
      if (pulse_mid && k == 30) start = 1'b1;
      else if (!keep_start)     start = 1'b0;
      @(negedge clk);
    end
    check_eq("finish_flags", {busy_m, done_m}, 2'b01);
    check_eq("mismatch_cnt", cnt_m, 64'(ecnt));
    check_eq("pass", pass_m, 64'(ecnt == 0));
    check_eq("cap_tbl", cap_m, circ_tbl);
    @(negedge clk);
    check_eq("idle_flags", {busy_m, done_m}, 2'b00);
    check_eq("idle_hold", {cap_m, cnt_m}, {circ_tbl, 4'(ecnt)});
    if (keep_start) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("restart", {busy_m, vec_m, cap_m, cnt_m, pass_m},
               {1'b1, 3'd0, 16'd0, 4'd0, 1'b0});
      got_done = 1'b0;
      for (int c = 0; c < 200 && !got_done; c++) begin
        @(negedge clk);
        if (done_m) got_done = 1'b1;
      end
      check_eq("second_done", 64'(got_done), 64'd1);
      check_eq("second_cap", cap_m, circ_tbl);
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_sweep();
    sel = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (44) @(negedge clk);
    check_eq("pre_reset_vec", vec_m, 64'd4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_reset", {vec_a, busy_a, done_a, cap_a, cnt_a, pass_a}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_reset_idle", {busy_a, vec_a}, 64'd0);
  endtask

  task automatic random_tables();
    circ_tbl = TW'($urandom);
    exp_tbl  = circ_tbl;
    for (int v = 0; v < int'(VN); v++)
      if ($urandom_range(3) == 0)
        exp_tbl[v*N_OUT +: N_OUT] = exp_tbl[v*N_OUT +: N_OUT] ^ 2'($urandom_range(3, 1));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_a", {vec_a, busy_a, done_a, cap_a, cnt_a, pass_a}, 64'd0);
    check_eq("reset_b", {vec_b, busy_b, done_b, cap_b, cnt_b, pass_b}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    circ_tbl = and_not_tbl();
    exp_tbl  = circ_tbl;
    do_sweep(1'b0, 1'b0, 1'b0);

    exp_tbl[5*N_OUT +: N_OUT] = ~exp_tbl[5*N_OUT +: N_OUT];
    do_sweep(1'b0, 1'b0, 1'b0);
    check_eq("cap_slice5", cap_a[5*N_OUT +: N_OUT], 64'd0);

    exp_tbl = circ_tbl;
    do_sweep(1'b0, 1'b1, 1'b1);

    reset_mid_sweep();
    do_sweep(1'b0, 1'b0, 1'b0);

    exp_tbl = ~circ_tbl;
    do_sweep(1'b0, 1'b0, 1'b0);

    exp_tbl = circ_tbl;
    do_sweep(1'b1, 1'b0, 1'b0);
    exp_tbl = ~circ_tbl;
    do_sweep(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      random_tables();
      do_sweep(1'(i & 1), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
